param_accumulator_harvard_cpu: RTL and testbench

Parametrised successor to the team's nibble accumulator Harvard CPU. Width is generalised through DATA_W and PC_W, and the block adds a subtract-with-carry instruction. It also adds a hardware return stack for CALL/RET and a ready/stall handshake on data memory. The core sits between a separate instruction ROM (indexed by program_counter) and a data RAM (address_out/data_out/data_in).

---
 rtl/param_accumulator_harvard_cpu.sv | 169 ++++++++++++++++
 tb/tb_param_accumulator_harvard_cpu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_accumulator_harvard_cpu.sv
// -----------------------------------------------------------------------------
// param_accumulator_harvard_cpu
//
// Parametrised accumulator CPU with Harvard memories: the instruction ROM is
// indexed by program_counter and the data RAM is accessed via
// address_out/data_out/data_in with a mem_ready stall handshake. The core has
// a hardware return stack for CALL/RET, and a stack overflow or underflow
// freezes the core in a fault state.
//
// Parameters : DATA_W (acc/data/address width), PC_W (pc width),
//              STACK_DEPTH (return-stack entries, >= 1)
// Ports      : clk, reset (async, active low)
//              instruction  - {opcode[3:0], field[FW-1:0]} from ROM
//              data_in      - RAM read data, mem_ready - RAM handshake
//              data_out     - accumulator, address_out - field[DATA_W-1:0]
//              mem_req      - memory opcode in RUN, write_to_memory - STA in RUN
//              program_counter, halted, fault
// Optional   : define ACC_CPU_RETIRED_COUNT_EN to add a saturating 16-bit
//              retired_count output.
// -----------------------------------------------------------------------------
module param_accumulator_harvard_cpu #(
    parameter int  DATA_W      = 8,
    parameter int  PC_W        = 8,
    parameter int  STACK_DEPTH = 4,
    localparam int FW          = (DATA_W > PC_W) ? DATA_W : PC_W,
    localparam int INSTR_W     = 4 + FW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               mem_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic [DATA_W-1:0]  address_out,
    output logic               mem_req,
    output logic               write_to_memory,
    output logic [PC_W-1:0]    program_counter,
    output logic               halted,
    output logic               fault
`ifdef ACC_CPU_RETIRED_COUNT_EN
    ,
    output logic [15:0]        retired_count
`endif
);
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic              carry, carry_n;
    logic [PC_W-1:0]   pc_n, pc_inc, target;
    logic [SP_W-1:0]   sp, sp_n;
    // Sized to the full sp range so sp indexes it without truncation;
    // entries at STACK_DEPTH and above are never written.
    logic [PC_W-1:0]   stack [0:(1<<SP_W)-1];
    logic [3:0]        op;
    logic [FW-1:0]     fld;
    logic [DATA_W-1:0] operand, addend;
    logic [DATA_W:0]   sum;
    logic              is_mem, stall, push, retire;

    // Decode and data-RAM handshake
    always_comb begin
        op              = instruction[INSTR_W-1 -: 4];
        fld             = instruction[FW-1:0];
        target          = fld[PC_W-1:0];
        // Even opcodes up to 8 (STA, LDA/ADC/SBC/NOR m) read or write RAM
        is_mem          = !op[0] && (op <= 4'h8);
        mem_req         = (state == S_RUN) && is_mem;
        write_to_memory = mem_req && (op == 4'h0);
        stall           = mem_req && !mem_ready;
        operand         = op[0] ? fld[DATA_W-1:0] : data_in;
        // SBC is ADC of the inverted operand; carry=1 means no borrow
        addend          = (op[3:1] == 3'b011) ? ~operand : operand;
        sum             = {1'b0, acc} + {1'b0, addend} + {{DATA_W{1'b0}}, carry};
        pc_inc          = program_counter + PC_W'(1);
    end

    assign data_out    = acc;
    assign address_out = fld[DATA_W-1:0];

    // Next state; a stalled or non-RUN cycle leaves everything as it is
    always_comb begin
        acc_n   = acc;
        carry_n = carry;
        pc_n    = program_counter;
        sp_n    = sp;
        state_n = state;
        push    = 1'b0;
        retire  = 1'b0;
        if (state == S_RUN && !stall) begin
            retire = 1'b1;
            pc_n   = pc_inc;
            case (op)
                4'h1: begin
                    state_n = S_HALT;
                    pc_n    = program_counter;
                    retire  = 1'b0;
                end
                4'h2, 4'h3:             acc_n = operand;
                4'h4, 4'h5, 4'h6, 4'h7: {carry_n, acc_n} = sum;
                4'h8, 4'h9:             acc_n = ~(acc | operand);
                4'hA:                   carry_n = fld[0];
                4'hB: if (acc != '0)    pc_n = target;
                4'hC: if (!carry)       pc_n = target;
                4'hD:                   pc_n = target;
                4'hE: begin
                    if (sp == SP_FULL) begin
                        state_n = S_FAULT;
                        pc_n    = program_counter;
                        retire  = 1'b0;
                    end else begin
                        push = 1'b1;
                        sp_n = sp + SP_W'(1);
                        pc_n = target;
                    end
                end
                4'hF: begin
                    if (sp == '0) begin
                        state_n = S_FAULT;
                        pc_n    = program_counter;
                        retire  = 1'b0;
                    end else begin
                        sp_n = sp - SP_W'(1);
                        pc_n = stack[sp - SP_W'(1)];
                    end
                end
                default: ;  // STA: the RAM takes data_out on this edge
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_RUN;
            acc             <= '0;
            carry           <= 1'b0;
            program_counter <= '0;
            sp              <= '0;
            halted          <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_n;
            acc             <= acc_n;
            carry           <= carry_n;
            program_counter <= pc_n;
            sp              <= sp_n;
            halted          <= (state_n != S_RUN);
            fault           <= (state_n == S_FAULT);
        end
    end

    // Stack contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc_inc;
    end

`ifdef ACC_CPU_RETIRED_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired_count <= '0;
        else if (retire && retired_count != 16'hFFFF)
            retired_count <= retired_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_param_accumulator_harvard_cpu.sv
// -----------------------------------------------------------------------------
// Testbench for param_accumulator_harvard_cpu (default parameters: DATA_W=8,
// PC_W=8, STACK_DEPTH=4, 12-bit instructions). The bench runs directed steps
// followed by random programs. Every cycle is compared against an
// integer-level reference model that uses a queue as the return stack.
// -----------------------------------------------------------------------------
module tb_param_accumulator_harvard_cpu;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] instruction = 12'h000;
    logic [7:0]  data_in = 8'h00;
    logic        mem_ready = 1'b1;
    logic [7:0]  data_out, address_out, program_counter;
    logic        mem_req, write_to_memory, halted, fault;
`ifdef ACC_CPU_RETIRED_COUNT_EN
    logic [15:0] retired_count;
`endif

    param_accumulator_harvard_cpu #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .data_in(data_in),
        .mem_ready(mem_ready), .data_out(data_out), .address_out(address_out),
        .mem_req(mem_req), .write_to_memory(write_to_memory),
        .program_counter(program_counter), .halted(halted), .fault(fault)
`ifdef ACC_CPU_RETIRED_COUNT_EN
        , .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: state 0=run, 1=halt, 2=fault
    int m_acc, m_carry, m_pc, m_state, m_ret;
    int m_stack[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_carry = 0; m_pc = 0; m_state = 0; m_ret = 0;
        m_stack.delete();
    endtask

    function automatic bit is_mem_op(input int op);
        return (op % 2 == 0) && (op <= 8);
    endfunction

    task automatic model_step(input logic [11:0] ins, input logic [7:0] din, input logic rdy);
        int op, f, v, t, nxt;
        if (m_state != 0) return;
        op = int'(ins[11:8]);
        f  = int'(ins[7:0]);
        if (is_mem_op(op) && !rdy) return;
        v   = (op % 2 == 1) ? f : int'(din);
        nxt = (m_pc + 1) % 256;
        case (op)
            1: begin m_state = 1; return; end
            2, 3: m_acc = v;
            4, 5: begin t = m_acc + v + m_carry; m_acc = t % 256; m_carry = t / 256; end
            6, 7: begin
                t = m_acc - v - (1 - m_carry);
                m_carry = (t >= 0) ? 1 : 0;
                m_acc = (t + 256) % 256;
            end
            8, 9: m_acc = 255 - (m_acc | v);
            10: m_carry = f % 2;
            11: if (m_acc != 0) nxt = f;
            12: if (m_carry == 0) nxt = f;
            13: nxt = f;
            14: begin
                if (m_stack.size() == DEPTH) begin m_state = 2; return; end
                m_stack.push_back((m_pc + 1) % 256);
                nxt = f;
            end
            15: begin
                if (m_stack.size() == 0) begin m_state = 2; return; end
                nxt = m_stack.pop_back();
            end
            default: ;
        endcase
        m_pc = nxt;
        if (m_ret < 65535) m_ret++;
    endtask

    // Compare every visible output with the model for the instruction now on the bus
    task automatic check_all();
        int  op;
        bit  run;
        op  = int'(instruction[11:8]);
        run = (m_state == 0);
        chk("pc", 16'(program_counter), 16'(m_pc));
        chk("acc", 16'(data_out), 16'(m_acc));
        chk("halted", 16'(halted), 16'(m_state != 0));
        chk("fault", 16'(fault), 16'(m_state == 2));
        chk("mem_req", 16'(mem_req), 16'(run && is_mem_op(op)));
        chk("wr", 16'(write_to_memory), 16'(run && op == 0));
        chk("addr", 16'(address_out), 16'(instruction[7:0]));
`ifdef ACC_CPU_RETIRED_COUNT_EN
        chk("retired", retired_count, 16'(m_ret));
`endif
    endtask

    task automatic cycle(input logic [11:0] ins, input logic [7:0] din, input logic rdy);
        @(negedge clk);
        instruction = ins; data_in = din; mem_ready = rdy;
        #1 check_all();
        @(posedge clk);
        #1 model_step(ins, din, rdy);
    endtask

    // After release one edge passes before the next cycle() drives the bus;
    // a stalled LDA m is left on the bus so that edge changes nothing.
    task automatic release_reset();
        @(negedge clk);
        instruction = 12'h23C; mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1 model_reset();
        chk("rst_pc", 16'(program_counter), 16'h0);
        chk("rst_acc", 16'(data_out), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_fault", 16'(fault), 16'h0);
        release_reset();
    endtask

    // Reset asserted away from any clock edge must act immediately
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        chk({tag, "_pc"}, 16'(program_counter), 16'h0);
        chk({tag, "_acc"}, 16'(data_out), 16'h0);
        chk({tag, "_halted"}, 16'(halted), 16'h0);
        chk({tag, "_fault"}, 16'(fault), 16'h0);
        release_reset();
    endtask

    function automatic logic [11:0] rand_ins();
        int op;
        op = $urandom_range(0, 15);
        if (op == 1 && $urandom_range(0, 19) != 0) op = 3;
        if (op == 15 && m_stack.size() == 0 && $urandom_range(0, 9) != 0) op = 13;
        if (op == 14 && m_stack.size() == DEPTH && $urandom_range(0, 9) != 0) op = 15;
        return {4'(op), 8'($urandom)};
    endfunction

    initial begin
        logic [11:0] ins;
        logic        rdy, held;

        // 1: ADC with carry out, JNC not taken
        do_reset();
        cycle(12'h305, 8'h00, 1'b1);
        cycle(12'h5FC, 8'h00, 1'b1);
        chk("t1_acc", 16'(data_out), 16'h01);
        chk("t1_pc", 16'(program_counter), 16'h02);
        cycle(12'hC10, 8'h00, 1'b1);
        chk("t1_jnc", 16'(program_counter), 16'h03);

        // 2: SBC without and with borrow
        cycle(12'hA01, 8'h00, 1'b1);
        cycle(12'h310, 8'h00, 1'b1);
        cycle(12'h701, 8'h00, 1'b1);
        chk("t2_acc0f", 16'(data_out), 16'h0F);
        cycle(12'hC50, 8'h00, 1'b1);
        chk("t2_c1", 16'(program_counter), 16'h07);
        cycle(12'h720, 8'h00, 1'b1);
        chk("t2_accef", 16'(data_out), 16'hEF);
        cycle(12'hC30, 8'h00, 1'b1);
        chk("t2_c0", 16'(program_counter), 16'h30);

        // 3: stalled load and store
        for (int i = 0; i < 3; i++) begin
            cycle(12'h23C, 8'h5A, 1'b0);
            chk("t3_ld_pc", 16'(program_counter), 16'h30);
            chk("t3_ld_acc", 16'(data_out), 16'hEF);
        end
        cycle(12'h23C, 8'h5A, 1'b1);
        chk("t3_ld_done", 16'(data_out), 16'h5A);
        chk("t3_ld_pc1", 16'(program_counter), 16'h31);
        for (int i = 0; i < 2; i++) begin
            cycle(12'h040, 8'h00, 1'b0);
            chk("t3_st_wr", 16'(write_to_memory), 16'h1);
            chk("t3_st_pc", 16'(program_counter), 16'h31);
        end
        cycle(12'h040, 8'h00, 1'b1);
        chk("t3_st_pc1", 16'(program_counter), 16'h32);

        // 4: CALL/RET, then overflow on the 5th nested CALL
        do_reset();
        for (int i = 0; i < 4; i++) cycle(12'h300, 8'h00, 1'b1);
        cycle(12'hE20, 8'h00, 1'b1);
        chk("t4_call", 16'(program_counter), 16'h20);
        cycle(12'hF00, 8'h00, 1'b1);
        chk("t4_ret", 16'(program_counter), 16'h05);
        cycle(12'hE30, 8'h00, 1'b1);
        cycle(12'hE40, 8'h00, 1'b1);
        cycle(12'hE50, 8'h00, 1'b1);
        cycle(12'hE60, 8'h00, 1'b1);
        chk("t4_nest", 16'(program_counter), 16'h60);
        cycle(12'hE70, 8'h00, 1'b1);
        chk("t4_ovf_fault", 16'(fault), 16'h1);
        chk("t4_ovf_halted", 16'(halted), 16'h1);
        chk("t4_ovf_pc", 16'(program_counter), 16'h60);
        cycle(12'h305, 8'h00, 1'b1);
        chk("t4_frozen_pc", 16'(program_counter), 16'h60);
        chk("t4_frozen_acc", 16'(data_out), 16'h00);

        // 5: underflow fault, then HALT
        do_reset();
        cycle(12'hF00, 8'h00, 1'b1);
        chk("t5_unf_fault", 16'(fault), 16'h1);
        chk("t5_unf_pc", 16'(program_counter), 16'h00);
        do_reset();
        cycle(12'h301, 8'h00, 1'b1);
        cycle(12'h100, 8'h00, 1'b1);
        chk("t5_halt", 16'(halted), 16'h1);
        chk("t5_halt_fault", 16'(fault), 16'h0);
        chk("t5_halt_pc", 16'(program_counter), 16'h01);
        cycle(12'h040, 8'h00, 1'b1);
        chk("t5_halt_wr", 16'(write_to_memory), 16'h0);
        chk("t5_halt_req", 16'(mem_req), 16'h0);
        chk("t5_halt_pc2", 16'(program_counter), 16'h01);

        // 6: asynchronous reset mid-stall and in FAULT
        do_reset();
        cycle(12'h307, 8'h00, 1'b1);
        cycle(12'h23C, 8'h11, 1'b0);
        chk("t6_pre", 16'(data_out), 16'h07);
        async_reset_check("t6_stall");
        cycle(12'h312, 8'h00, 1'b1);
        chk("t6_restart_pc", 16'(program_counter), 16'h01);
        chk("t6_restart_acc", 16'(data_out), 16'h12);
        cycle(12'hF00, 8'h00, 1'b1);
        chk("t6_fault", 16'(fault), 16'h1);
        async_reset_check("t6_fault");
        cycle(12'h305, 8'h00, 1'b1);
        chk("t6_after_pc", 16'(program_counter), 16'h01);

        // Random programs against the model; the ROM holds the word while stalled
        for (int r = 0; r < 4; r++) begin
            do_reset();
            held = 1'b0;
            ins  = 12'h000;
            for (int c = 0; c < 400; c++) begin
                if (!held) ins = rand_ins();
                rdy  = ($urandom_range(0, 3) != 0);
                held = (m_state == 0) && is_mem_op(int'(ins[11:8])) && !rdy;
                cycle(ins, 8'($urandom), rdy);
                if (m_state != 0) begin
                    cycle(rand_ins(), 8'($urandom), 1'b1);
                    break;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
